mig_app_responder: RTL and testbench
====================================

// Module: mig_app_responder
// PURPOSE
// Responder side of the MIG 7-series user (app_*) interface: stands in for the DDR3 MIG so
// that app-interface initiators can be simulated and FPGA-tested without external DRAM.
// - Accepts read/write commands and write data.
// - Stores 256-bit words in on-chip RAM.
// - Returns read data after a fixed latency.
// - Emulates calibration delay and periodic refresh back-pressure (app_rdy low).
// PARAMETERS
// MEM_DEPTH       1024  number of 256-bit words (power of 2)
// CALIB_CYCLES    64    ui_clk cycles from reset release to init_calib_complete
// READ_LATENCY    8     cycles from read-command pop to app_rd_data_valid (>=2)
// REFRESH_PERIOD  512   cycles between automatic refresh stalls
// REFRESH_STALL   16    cycles app_rdy is held low per refresh
// CMD_FIFO_DEPTH  4     queued commands (power of 2)
// WDF_DEPTH       4     queued write-data words (power of 2)
// PORTS
// ui_clk              in   1    single clock for all logic
// ui_clk_sync_rst     in   1    asynchronous, active-high reset
// app_addr            in   29   byte-lane address; +8 per 256-bit word
// app_cmd             in   3    3'b000 write, 3'b001 read, others illegal
// app_en              in   1    command valid
// app_rdy             out  1    command accepted when app_en & app_rdy
// app_wdf_data        in   256  write data
// app_wdf_mask        in   32   per-byte mask, 1 = byte NOT written
// app_wdf_wren        in   1    write-data valid
// app_wdf_end         in   1    last beat of the write burst (always equal to wren; checked)
// app_wdf_rdy         out  1    write data accepted when app_wdf_wren & app_wdf_rdy
// app_rd_data         out  256  read data
// app_rd_data_valid   out  1    one-cycle pulse per read word
// app_rd_data_end     out  1    equals app_rd_data_valid
// app_ref_req         in   1    user refresh request
// app_ref_ack         out  1    one-cycle pulse when the user-requested refresh completes
// app_zq_req          in   1    ZQ request
// app_zq_ack          out  1    one-cycle pulse the cycle after app_zq_req
// app_sr_req          in   1    ignored
// app_sr_active       out  1    tied 0
// init_calib_complete out  1    sticky 1 after CALIB_CYCLES
// cmd_err             out  1    sticky: illegal app_cmd accepted, or wren without end
// BEHAVIOUR
// - Reset values:
//   - All outputs are 0, app_rd_data included.
//   - FIFOs and the read pipeline are flushed; the calibration and refresh counters clear.
//   - RAM contents are kept.
//   - Reset mid-operation drops in-flight reads with no valid pulse and restarts calibration.
// - Calibration: a counter runs from reset release; init_calib_complete rises on cycle CALIB_CYCLES.
//   Before that, app_rdy = app_wdf_rdy = 0.
// - app_rdy (combinational from registered state) = calib & !refresh_stall & !cmd_fifo_full.
// - app_wdf_rdy = calib & !wdf_full. It is unaffected by refresh.
// - Word index = app_addr[3 +: log2(MEM_DEPTH)]. Higher bits are ignored, so addresses wrap.
//   app_addr[2:0] is ignored.
// - Accepted command: pushed to the cmd FIFO as {cmd, index}.
//   - Illegal cmd: not pushed; cmd_err is set.
// - Write data may arrive before, with or after its command. It is matched in order through the WDF FIFO.
// - Execution: at most one command per cycle, strictly in order, starting the cycle after it is pushed.
//   - Write at head: executes only when the WDF is non-empty.
//     It pops both FIFOs and writes the unmasked bytes; the head stalls until data arrives.
//   - Read at head: pops, reads the RAM, and enters a READ_LATENCY-deep valid/data pipeline.
//   - A read after a write to the same index returns the new data.
//   - If one command pops and another pushes in the same cycle, the FIFO count is unchanged.
// - Refresh:
//   - An auto refresh starts when the period counter (running after calibration) hits REFRESH_PERIOD-1.
//     An app_ref_req seen while idle also starts one.
//   - Stall is REFRESH_STALL cycles with app_rdy=0. It starts the cycle after the trigger;
//     a command accepted in the trigger cycle is kept.
//   - Queued commands keep executing and the read pipeline keeps draining during the stall.
//   - app_ref_ack pulses in the last stall cycle, for requested refreshes only.
//   - The period counter restarts at the end of the stall.
//   - A request during a stall is latched and served by the next stall.
// - There is no read-data back-pressure; valid pulses are never dropped.
// STRUCTURE
// - Package mig_app_pkg: CMD_WRITE=3'b000, CMD_READ=3'b001, APP_ADDR_W=29, APP_DATA_W=256, APP_MASK_W=32.
// - Sub-module sync_fifo (parametric width/depth, registered count, full/empty).
//   It is instantiated twice: cmd FIFO and WDF.
// - RAM is an inferred byte-enable single-port array. The read pipeline is a shift register.
// TESTING
// - Reset, then idle: init_calib_complete and app_rdy rise exactly CALIB_CYCLES=64 cycles after
//   reset release; all outputs are 0 before that.
// - Write 0xA5.. to addr 0x10 with data together with the command, then read 0x10.
//   The command is accepted at N; valid at N+1+8 with 0xA5.., and app_rd_data_end=1.
// - Write data presented 3 cycles before its command, then the command; then a masked write with
//   mask=32'h0000_000F to the same word. Readback: low 4 bytes keep the old value, the rest are new.
// - Write 5 commands with no data: app_rdy drops after 4 (FIFO full).
//   Feed the data: all 5 execute in order; readback matches.
// - Refresh: with app_en held high, after REFRESH_PERIOD cycles app_rdy is low for exactly 16 cycles.
//   app_ref_req triggers a stall and one app_ref_ack pulse in its last cycle.
// - app_cmd=3'b010, and addr 0x1000_0010 at MEM_DEPTH=1024:
//   cmd_err=1 and no RAM change; the wrapped address aliases index 2.

Source files
------------

// File: rtl/mig_app_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mig_app_pkg                                                                |
// | Shared constants and types for the MIG app-interface responder.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mig_app_pkg;
  localparam logic [2:0] CMD_WRITE  = 3'b000;
  localparam logic [2:0] CMD_READ   = 3'b001;
  localparam int         APP_ADDR_W = 29;
  localparam int         APP_DATA_W = 256;
  localparam int         APP_MASK_W = 32;

  typedef enum logic [0:0] {
    REF_IDLE  = 1'b0,
    REF_STALL = 1'b1
  } ref_state_e;
endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_fifo                                                                  |
// | Single-clock FIFO with registered occupancy count; DEPTH a power of 2 >= 2.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign dout   = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      // simultaneous push and pop leaves the occupancy unchanged
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end
endmodule
`default_nettype wire

// File: rtl/mig_app_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mig_app_responder                                                          |
// | On-chip stand-in for the DDR3 MIG user interface (calib, refresh, r/w).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mig_app_responder
  import mig_app_pkg::*;
#(
  parameter int MEM_DEPTH      = 1024,
  parameter int CALIB_CYCLES   = 64,
  parameter int READ_LATENCY   = 8,
  parameter int REFRESH_PERIOD = 512,
  parameter int REFRESH_STALL  = 16,
  parameter int CMD_FIFO_DEPTH = 4,
  parameter int WDF_DEPTH      = 4
) (
  input  logic                  ui_clk,
  input  logic                  ui_clk_sync_rst,
  input  logic [APP_ADDR_W-1:0] app_addr,
  input  logic [2:0]            app_cmd,
  input  logic                  app_en,
  output logic                  app_rdy,
  input  logic [APP_DATA_W-1:0] app_wdf_data,
  input  logic [APP_MASK_W-1:0] app_wdf_mask,
  input  logic                  app_wdf_wren,
  input  logic                  app_wdf_end,
  output logic                  app_wdf_rdy,
  output logic [APP_DATA_W-1:0] app_rd_data,
  output logic                  app_rd_data_valid,
  output logic                  app_rd_data_end,
  input  logic                  app_ref_req,
  output logic                  app_ref_ack,
  input  logic                  app_zq_req,
  output logic                  app_zq_ack,
  input  logic                  app_sr_req,
  output logic                  app_sr_active,
  output logic                  init_calib_complete,
  output logic                  cmd_err
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CMD_W = 3 + IDX_W;
  localparam int WDF_W = APP_MASK_W + APP_DATA_W;
  localparam int CAL_W = $clog2(CALIB_CYCLES + 1);
  localparam int PER_W = $clog2(REFRESH_PERIOD + 1);
  localparam int STL_W = $clog2(REFRESH_STALL + 1);

  logic             r_calib;
  logic [CAL_W-1:0] r_cal_cnt;
  ref_state_e       r_ref_state, w_ref_state_nxt;
  logic [PER_W-1:0] r_per_cnt;
  logic [STL_W-1:0] r_stl_cnt;
  logic             r_ref_user, r_ref_pend, r_cmd_err, r_zq_ack;
  logic             w_stall, w_stall_last, w_trig_auto, w_trig_user, w_trig;
  logic             w_cmd_hs, w_cmd_legal, w_cmd_push, w_cmd_pop, w_cmd_full, w_cmd_empty;
  logic [CMD_W-1:0] w_cmd_dout;
  logic             w_wdf_push, w_wdf_full, w_wdf_empty;
  logic [WDF_W-1:0] w_wdf_dout;
  logic [IDX_W-1:0] w_idx;
  logic             w_exec_wr, w_exec_rd;
  logic             w_unused;

  logic [APP_DATA_W-1:0] r_mem [MEM_DEPTH];
  logic [APP_DATA_W-1:0] r_ram_q;
  logic [READ_LATENCY-1:0] r_rd_vld;
  logic [APP_DATA_W-1:0] r_rd_pipe [READ_LATENCY-1];

  assign w_unused = ^{app_sr_req, app_addr[2:0], app_addr[APP_ADDR_W-1:3+IDX_W]};

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      r_calib   <= 1'b0;
      r_cal_cnt <= '0;
    end else if (!r_calib) begin
      if (r_cal_cnt == CAL_W'(CALIB_CYCLES - 1)) r_calib <= 1'b1;
      r_cal_cnt <= r_cal_cnt + 1'b1;
    end
  end

  assign w_stall      = (r_ref_state == REF_STALL);
  assign w_stall_last = w_stall && (r_stl_cnt == STL_W'(REFRESH_STALL - 1));
  assign w_trig       = w_trig_auto | w_trig_user;

  always_comb begin
    w_ref_state_nxt = r_ref_state;
    w_trig_auto     = 1'b0;
    w_trig_user     = 1'b0;
    case (r_ref_state)
      REF_IDLE: begin
        w_trig_auto = r_calib && (r_per_cnt == PER_W'(REFRESH_PERIOD - 1));
        w_trig_user = r_calib && (app_ref_req || r_ref_pend);
        if (w_trig_auto || w_trig_user) w_ref_state_nxt = REF_STALL;
      end
      REF_STALL: if (w_stall_last) w_ref_state_nxt = REF_IDLE;
      default:   w_ref_state_nxt = REF_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      r_ref_state <= REF_IDLE;
      r_per_cnt   <= '0;
      r_stl_cnt   <= '0;
      r_ref_user  <= 1'b0;
      r_ref_pend  <= 1'b0;
    end else begin
      r_ref_state <= w_ref_state_nxt;
      r_stl_cnt   <= (w_stall && !w_stall_last) ? r_stl_cnt + 1'b1 : '0;
      if (w_stall_last)            r_per_cnt <= '0;
      else if (r_calib && !w_stall) r_per_cnt <= r_per_cnt + 1'b1;
      // a request arriving mid-stall is held for the next idle cycle
      if (w_stall && app_ref_req) r_ref_pend <= 1'b1;
      else if (w_trig_user)       r_ref_pend <= 1'b0;
      if (w_trig) r_ref_user <= w_trig_user;
    end
  end

  assign app_ref_ack = w_stall_last & r_ref_user;

  assign app_rdy     = r_calib & ~w_stall & ~w_cmd_full;
  assign app_wdf_rdy = r_calib & ~w_wdf_full;
  assign w_cmd_hs    = app_en & app_rdy;
  assign w_cmd_legal = (app_cmd == CMD_WRITE) || (app_cmd == CMD_READ);
  assign w_cmd_push  = w_cmd_hs & w_cmd_legal;
  assign w_wdf_push  = app_wdf_wren & app_wdf_rdy;

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_FIFO_DEPTH)) u_cmd_fifo (
    .clk   (ui_clk),
    .rst   (ui_clk_sync_rst),
    .push  (w_cmd_push),
    .din   ({app_cmd, app_addr[3 +: IDX_W]}),
    .pop   (w_cmd_pop),
    .dout  (w_cmd_dout),
    .full  (w_cmd_full),
    .empty (w_cmd_empty)
  );

  sync_fifo #(.WIDTH(WDF_W), .DEPTH(WDF_DEPTH)) u_wdf (
    .clk   (ui_clk),
    .rst   (ui_clk_sync_rst),
    .push  (w_wdf_push),
    .din   ({app_wdf_mask, app_wdf_data}),
    .pop   (w_exec_wr),
    .dout  (w_wdf_dout),
    .full  (w_wdf_full),
    .empty (w_wdf_empty)
  );

  // a write at the head waits for its data; reads never wait
  assign w_idx     = w_cmd_dout[IDX_W-1:0];
  assign w_exec_wr = ~w_cmd_empty & (w_cmd_dout[CMD_W-1 -: 3] == CMD_WRITE) & ~w_wdf_empty;
  assign w_exec_rd = ~w_cmd_empty & (w_cmd_dout[CMD_W-1 -: 3] == CMD_READ);
  assign w_cmd_pop = w_exec_wr | w_exec_rd;

  always_ff @(posedge ui_clk) begin
    if (w_exec_wr) begin
      for (int b = 0; b < APP_MASK_W; b++) begin
        if (!w_wdf_dout[APP_DATA_W + b]) r_mem[w_idx][8*b +: 8] <= w_wdf_dout[8*b +: 8];
      end
    end
    if (w_exec_rd) r_ram_q <= r_mem[w_idx];
  end

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      r_rd_vld <= '0;
      for (int i = 0; i < READ_LATENCY - 1; i++) r_rd_pipe[i] <= '0;
      r_cmd_err <= 1'b0;
      r_zq_ack  <= 1'b0;
    end else begin
      r_rd_vld     <= {r_rd_vld[READ_LATENCY-2:0], w_exec_rd};
      r_rd_pipe[0] <= r_rd_vld[0] ? r_ram_q : '0;
      for (int i = 1; i < READ_LATENCY - 1; i++) r_rd_pipe[i] <= r_rd_pipe[i-1];
      if ((w_cmd_hs & ~w_cmd_legal) | (app_wdf_wren & ~app_wdf_end)) r_cmd_err <= 1'b1;
      r_zq_ack <= app_zq_req;
    end
  end

  assign app_rd_data         = r_rd_pipe[READ_LATENCY-2];
  assign app_rd_data_valid   = r_rd_vld[READ_LATENCY-1];
  assign app_rd_data_end     = r_rd_vld[READ_LATENCY-1];
  assign app_zq_ack          = r_zq_ack;
  assign app_sr_active       = 1'b0;
  assign init_calib_complete = r_calib;
  assign cmd_err             = r_cmd_err;
endmodule
`default_nettype wire

// File: tb/tb_mig_app_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mig_app_responder                                                       |
// | Directed bench with an in-order memory model and per-cycle read checker.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mig_app_responder;
  logic         ui_clk = 1'b0;
  logic         ui_clk_sync_rst = 1'b1;
  logic [28:0]  app_addr = '0;
  logic [2:0]   app_cmd = '0;
  logic         app_en = 1'b0;
  logic         app_rdy;
  logic [255:0] app_wdf_data = '0;
  logic [31:0]  app_wdf_mask = '0;
  logic         app_wdf_wren = 1'b0;
  logic         app_wdf_end = 1'b0;
  logic         app_wdf_rdy;
  logic [255:0] app_rd_data;
  logic         app_rd_data_valid, app_rd_data_end;
  logic         app_ref_req = 1'b0;
  logic         app_ref_ack;
  logic         app_zq_req = 1'b0;
  logic         app_zq_ack;
  logic         app_sr_req = 1'b0;
  logic         app_sr_active, init_calib_complete, cmd_err;

  mig_app_responder dut (
    .ui_clk(ui_clk), .ui_clk_sync_rst(ui_clk_sync_rst),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end),
    .app_ref_req(app_ref_req), .app_ref_ack(app_ref_ack),
    .app_zq_req(app_zq_req), .app_zq_ack(app_zq_ack),
    .app_sr_req(app_sr_req), .app_sr_active(app_sr_active),
    .init_calib_complete(init_calib_complete), .cmd_err(cmd_err)
  );

  always #5 ui_clk = ~ui_clk;

  int cyc = 0;
  always @(posedge ui_clk) cyc++;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask

  // ---------------- behavioural model: in-order command/data pairing ----------------
  typedef struct { bit wr; int idx; } mcmd_t;
  logic [255:0] mdl_mem [int];
  mcmd_t        mq[$];
  logic [287:0] dq[$];
  logic [255:0] exp_q[$];

  function automatic int idx_of(input logic [28:0] a);
    return int'(a >> 3) % 1024;
  endfunction

  task automatic model_step();
    logic [287:0] d;
    logic [255:0] w;
    while (mq.size() > 0) begin
      if (mq[0].wr) begin
        if (dq.size() == 0) break;
        d = dq.pop_front();
        w = mdl_mem.exists(mq[0].idx) ? mdl_mem[mq[0].idx] : '0;
        for (int b = 0; b < 32; b++) if (!d[256+b]) w[8*b +: 8] = d[8*b +: 8];
        mdl_mem[mq[0].idx] = w;
      end else begin
        exp_q.push_back(mdl_mem.exists(mq[0].idx) ? mdl_mem[mq[0].idx] : '0);
      end
      void'(mq.pop_front());
    end
  endtask

  task automatic model_cmd(input logic [2:0] c, input logic [28:0] a);
    mcmd_t m;
    m.idx = idx_of(a);
    if (c == 3'b000) begin m.wr = 1'b1; mq.push_back(m); end
    else if (c == 3'b001) begin m.wr = 1'b0; mq.push_back(m); end
    model_step();
  endtask

  // ---------------- compare process ----------------
  int           n_valid = 0;
  int           last_valid_cyc = 0;
  logic [255:0] last_valid_data = '0;

  always @(negedge ui_clk) begin
    check("rd_data_end", {255'd0, app_rd_data_end}, {255'd0, app_rd_data_valid});
    check("sr_active", {255'd0, app_sr_active}, 256'd0);
    if (app_rd_data_valid) begin
      n_valid++;
      last_valid_cyc  = cyc;
      last_valid_data = app_rd_data;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got %h expected no pulse", app_rd_data);
      end else begin
        check("rd_data", app_rd_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  int last_acc_cyc = 0;

  task automatic send_cmd(input logic [2:0] c, input logic [28:0] a);
    int n = 0;
    @(negedge ui_clk);
    app_en = 1'b1; app_cmd = c; app_addr = a;
    #1;
    while (!app_rdy && n < 2000) begin @(negedge ui_clk); #1; n++; end
    if (!app_rdy) timeout("cmd_accept");
    else begin last_acc_cyc = cyc; model_cmd(c, a); end
    @(posedge ui_clk); #1;
    app_en = 1'b0;
  endtask

  task automatic send_wd(input logic [255:0] d, input logic [31:0] m);
    int n = 0;
    @(negedge ui_clk);
    app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = d; app_wdf_mask = m;
    #1;
    while (!app_wdf_rdy && n < 2000) begin @(negedge ui_clk); #1; n++; end
    if (!app_wdf_rdy) timeout("wdf_accept");
    else begin dq.push_back({m, d}); model_step(); end
    @(posedge ui_clk); #1;
    app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
  endtask

  task automatic send_both(input logic [28:0] a, input logic [255:0] d, input logic [31:0] m);
    fork
      send_cmd(3'b000, a);
      send_wd(d, m);
    join
  endtask

  task automatic wait_valids(input int target);
    int n = 0;
    while (n_valid < target && n < 200) begin @(negedge ui_clk); #2; n++; end
    if (n_valid < target) timeout("read_return");
  endtask

  // ---------------- stimulus ----------------
  logic [255:0] A5, D0, D1, ALIAS, DK, exp_mask;
  bit           rdy_hist [540];
  int           k, n0, acc, first_low, low_run, acks, ack_at;
  bit           nz;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    A5    = {8{32'hA5A5_A5A5}};
    D0    = {8{32'h1122_3344}};
    D1    = {8{32'hCAFE_F00D}};
    ALIAS = {8{32'h5A5A_0002}};
    exp_mask = {D1[255:32], D0[31:0]};

    // reset state and calibration delay
    repeat (3) @(negedge ui_clk);
    #1;
    check("reset_outputs", {app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, app_ref_ack,
          app_zq_ack, app_sr_active, init_calib_complete, cmd_err, |app_rd_data}, 256'd0);
    @(negedge ui_clk);
    ui_clk_sync_rst = 1'b0;
    nz = 1'b0;
    for (k = 1; k <= 100; k++) begin
      @(negedge ui_clk); #1;
      if (init_calib_complete) break;
      if (app_rdy || app_wdf_rdy || app_rd_data_valid || app_ref_ack || cmd_err || (|app_rd_data)) nz = 1'b1;
    end
    check("calib_cycles", k, 64);
    check("pre_calib_zero", {255'd0, nz}, 256'd0);
    check("rdy_after_calib", {254'd0, app_rdy, app_wdf_rdy}, 256'd3);

    // write with data alongside the command, then read with latency check
    send_both(29'h10, A5, 32'h0);
    n0 = n_valid;
    send_cmd(3'b001, 29'h10);
    acc = last_acc_cyc;
    wait_valids(n0 + 1);
    check("rd_latency", last_valid_cyc - acc, 9);
    check("rd_data_a5", last_valid_data, A5);

    // data ahead of its command, then a masked overwrite of the low 4 bytes' complement
    send_wd(D0, 32'h0);
    repeat (2) @(negedge ui_clk);
    send_cmd(3'b000, 29'h20);
    send_both(29'h20, D1, 32'h0000_000F);
    n0 = n_valid;
    send_cmd(3'b001, 29'h20);
    wait_valids(n0 + 1);
    check("masked_rd", last_valid_data, exp_mask);

    // command FIFO fills at 4 while data is withheld
    for (int i = 0; i < 4; i++) send_cmd(3'b000, 29'h100 + 29'(8*i));
    @(negedge ui_clk); #1;
    check("rdy_fifo_full", {255'd0, app_rdy}, 256'd0);
    fork
      send_cmd(3'b000, 29'h120);
      for (int i = 0; i < 5; i++) send_wd({8{32'hBEEF_0000 + 32'(i)}}, 32'h0);
    join
    n0 = n_valid;
    for (int i = 0; i < 5; i++) send_cmd(3'b001, 29'h100 + 29'(8*i));
    wait_valids(n0 + 5);
    DK = {8{32'hBEEF_0004}};
    check("fifo_last_rd", last_valid_data, DK);

    // illegal command and address aliasing
    check("cmd_err_clear", {255'd0, cmd_err}, 256'd0);
    send_cmd(3'b010, 29'h10);
    check("cmd_err_illegal", {255'd0, cmd_err}, 256'd1);
    n0 = n_valid;
    send_cmd(3'b001, 29'h10);
    wait_valids(n0 + 1);
    check("illegal_no_write", last_valid_data, A5);
    send_both(29'h1000_0010, ALIAS, 32'h0);
    n0 = n_valid;
    send_cmd(3'b001, 29'h10);
    wait_valids(n0 + 1);
    check("alias_idx2", last_valid_data, ALIAS);

    // reset with a read in flight: it must vanish; RAM keeps its contents
    send_cmd(3'b001, 29'h10);
    repeat (3) @(negedge ui_clk);
    ui_clk_sync_rst = 1'b1;
    exp_q.delete(); mq.delete(); dq.delete();
    #1;
    check("reset2_outputs", {app_rdy, app_wdf_rdy, app_rd_data_valid, init_calib_complete,
          cmd_err, |app_rd_data}, 256'd0);
    repeat (2) @(negedge ui_clk);
    ui_clk_sync_rst = 1'b0;
    for (k = 0; k < 100; k++) begin
      @(negedge ui_clk); #1;
      if (init_calib_complete) break;
    end
    if (!init_calib_complete) timeout("recalib");

    // auto refresh with app_en held high
    app_en = 1'b1; app_cmd = 3'b001; app_addr = 29'h10;
    acks = 0;
    for (int i = 0; i < 540; i++) begin
      rdy_hist[i] = app_rdy;
      if (app_ref_ack) acks++;
      if (app_rdy) model_cmd(3'b001, 29'h10);
      @(negedge ui_clk); #1;
    end
    app_en = 1'b0;
    first_low = -1;
    for (int i = 0; i < 540; i++) if (!rdy_hist[i] && first_low < 0) first_low = i;
    low_run = 0;
    if (first_low >= 0)
      for (int i = first_low; i < 540 && !rdy_hist[i]; i++) low_run++;
    check("auto_ref_start", first_low, 512);
    check("auto_ref_len", low_run, 16);
    check("auto_ref_no_ack", acks, 0);

    // user refresh request
    @(negedge ui_clk);
    app_ref_req = 1'b1;
    @(negedge ui_clk);
    app_ref_req = 1'b0;
    low_run = 0; acks = 0; ack_at = -1;
    for (int j = 1; j <= 20; j++) begin
      #1;
      if (!app_rdy) low_run++;
      if (app_ref_ack) begin acks++; ack_at = j; end
      if (j == 17) check("user_ref_end_rdy", {255'd0, app_rdy}, 256'd1);
      @(negedge ui_clk);
    end
    check("user_ref_len", low_run, 16);
    check("user_ref_ack_cnt", acks, 1);
    check("user_ref_ack_pos", ack_at, 16);

    // ZQ handshake
    app_zq_req = 1'b1;
    #1;
    check("zq_ack_before", {255'd0, app_zq_ack}, 256'd0);
    @(negedge ui_clk);
    app_zq_req = 1'b0;
    #1;
    check("zq_ack_pulse", {255'd0, app_zq_ack}, 256'd1);
    @(negedge ui_clk); #1;
    check("zq_ack_after", {255'd0, app_zq_ack}, 256'd0);

    // write data without end flag
    check("cmd_err_pre_wren", {255'd0, cmd_err}, 256'd0);
    @(negedge ui_clk);
    app_wdf_wren = 1'b1; app_wdf_end = 1'b0;
    @(negedge ui_clk);
    app_wdf_wren = 1'b0;
    #1;
    check("cmd_err_wren_no_end", {255'd0, cmd_err}, 256'd1);

    for (k = 0; k < 100 && exp_q.size() > 0; k++) @(negedge ui_clk);
    check("reads_drained", exp_q.size(), 0);
    repeat (2) @(negedge ui_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
